// File: rtl/usart_tx_buffered.sv
// usart_tx_buffered: USART transmitter fed by a small FIFO. Words are queued
// through a valid/ready handshake and sent as START, DATA (LSB first),
// optional PARITY and STOP bits. Frames go out back to back while words wait.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle high, waiting for a queued word
// S_START  | start bit (low) on the line
// S_DATA   | data bits, LSB first, shifted out of shift_reg
// S_PARITY | parity bit (only entered when PARITY != 0)
// S_STOP   | stop bit(s) high; last one may pop the next word directly
module usart_tx_buffered #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [BW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  logic                   push;
  logic                   pop;
  logic                   baud_end;
  logic                   frame_end;
  logic [DATA_BITS-1:0]   head;
  logic                   head_parity;

  // ready comes straight from the registered count, so a pop on the same
  // edge never lets a full FIFO accept a word.
  assign ready       = (fifo_count != FULL_COUNT);
  assign push        = valid && ready;
  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign frame_end   = (state == S_STOP) && baud_end && (bit_cnt == STOP_LAST);
  assign pop         = (fifo_count != '0) && ((state == S_IDLE) || frame_end);
  assign head        = mem[rd_ptr];
  assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

  // FIFO storage; contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer with registered tx/busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shift_reg  <= head;
            parity_bit <= head_parity;
            state      <= S_START;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              done    <= 1'b1;
              // Chain straight into the next frame when a word is waiting.
              if (pop) begin
                shift_reg  <= head;
                parity_bit <= head_parity;
                state      <= S_START;
                tx         <= 1'b0;
              end else begin
                state <= S_IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_buffered.sv
// tb_usart_tx_buffered: four transmitter configurations share one clock and
// reset. Every cycle's tx/busy/done is logged; expected waveforms are built
// from frame rules (bit list repeated CLKS_PER_BIT times) and compared per frame.
module tb_usart_tx_buffered;

  localparam int CPB = 10;
  localparam int DBITS [4] = '{8, 8, 8, 7};
  localparam int SBITS [4] = '{1, 1, 1, 2};
  localparam int PARS  [4] = '{0, 2, 1, 0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] data0, data1, data2;
  logic [6:0] data3;
  logic [2:0] fc0;
  logic [3:0] fc1, fc2, fc3;

  logic [3:0] tx_log   [$];
  logic [3:0] busy_log [$];
  logic [3:0] done_log [$];
  logic [8:0] wq [4][$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 8N1, FIFO_DEPTH 4
  usart_tx_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset_n(reset_n), .data(data0), .valid(valid_v[0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fifo_count(fc0));
  // 8E1
  usart_tx_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .reset_n(reset_n), .data(data1), .valid(valid_v[1]), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fifo_count(fc1));
  // 8O1
  usart_tx_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(8)) u2 (
    .clk(clk), .reset_n(reset_n), .data(data2), .valid(valid_v[2]), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fifo_count(fc2));
  // 7N2
  usart_tx_buffered #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
    .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(8)) u3 (
    .clk(clk), .reset_n(reset_n), .data(data3), .valid(valid_v[3]), .ready(ready_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]), .fifo_count(fc3));

  // Log entry k holds the outputs settled after rising edge k+1.
  always @(negedge clk) begin
    tx_log.push_back(tx_v);
    busy_log.push_back(busy_v);
    done_log.push_back(done_v);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int i);
    return 1 + DBITS[i] + ((PARS[i] != 0) ? 1 : 0) + SBITS[i];
  endfunction

  function automatic logic [8:0] data_mask(input int i);
    return (9'h1 << DBITS[i]) - 9'h1;
  endfunction

  // Line level per cycle for one frame, from the framing rules.
  function automatic logic [127:0] exp_wave(input int i, input logic [8:0] w);
    logic [127:0] r;
    int ones;
    logic b;
    r = '0;
    ones = $countones(w & data_mask(i));
    for (int k = 0; k < frame_len(i); k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= DBITS[i]) b = w[k-1];
      else if (PARS[i] != 0 && k == DBITS[i] + 1) b = (PARS[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      else b = 1'b1;
      for (int c = 0; c < CPB; c++) r[k*CPB + c] = b;
    end
    return r;
  endfunction

  function automatic int ones_in(input int sel, input int i, input int a, input int n);
    int s;
    logic [3:0] t;
    s = 0;
    for (int k = a; k < a + n; k++) begin
      t = (sel == 0) ? tx_log[k] : (sel == 1) ? busy_log[k] : done_log[k];
      s += int'(t[i]);
    end
    return s;
  endfunction

  task automatic set_data(input int i, input logic [8:0] w);
    case (i)
      0: data0 = w[7:0];
      1: data1 = w[7:0];
      2: data2 = w[7:0];
      default: data3 = w[6:0];
    endcase
  endtask

  // Frames start at log index 'start' and run back to back, then the line idles.
  task automatic check_frames(input int i, input int start, input logic [8:0] words[$]);
    int len, s, n;
    logic [127:0] o, e;
    logic [3:0] t, u;
    len = frame_len(i) * CPB;
    n = words.size();
    check($sformatf("log_covered i%0d", i), 128'(tx_log.size() > start + n*len + 1), 128'(1));
    if (tx_log.size() <= start + n*len + 1) return;
    for (int f = 0; f < n; f++) begin
      s = start + f*len;
      o = '0;
      e = exp_wave(i, words[f]);
      for (int k = 0; k < len; k++) begin t = tx_log[s+k]; o[k] = t[i]; end
      check($sformatf("tx_frame i%0d f%0d", i, f), o, e);
      o = '0; e = '0;
      for (int k = 0; k < len; k++) begin t = busy_log[s+k]; o[k] = t[i]; e[k] = 1'b1; end
      check($sformatf("busy_frame i%0d f%0d", i, f), o, e);
      o = '0; e = '0; e[len-1] = 1'b1;
      for (int k = 0; k < len; k++) begin t = done_log[s+1+k]; o[k] = t[i]; end
      check($sformatf("done_frame i%0d f%0d", i, f), o, e);
    end
    s = start + n*len;
    t = tx_log[s];
    u = busy_log[s];
    check($sformatf("idle_after i%0d", i), {126'b0, t[i], u[i]}, {126'b0, 1'b1, 1'b0});
    check($sformatf("done_total i%0d", i), 128'(ones_in(2, i, start, n*len + 2)), 128'(n));
  endtask

  initial begin
    int l0;
    int n [4];
    int mx;
    logic [8:0] w;

    reset_n = 1'b0;
    valid_v = '0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    tick(3);
    check("reset_lines", {tx_v, busy_v, done_v, ready_v}, {4'hf, 4'h0, 4'h0, 4'hf});
    check("reset_count", {fc0, fc1, fc2, fc3}, '0);
    reset_n = 1'b1;
    tick(2);

    // 8N1 single word 0xA5, with push/pop latency
    l0 = tx_log.size();
    set_data(0, 9'h0A5);
    valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    check("a5_count_after_push", {fc0, tx_v[0], busy_v[0]}, {3'd1, 1'b1, 1'b0});
    tick(1);
    check("a5_pop_start", {fc0, tx_v[0], busy_v[0]}, {3'd0, 1'b0, 1'b1});
    tick(110);
    wq[0].delete(); wq[0].push_back(9'h0A5);
    check_frames(0, l0 + 2, wq[0]);

    // Parity even/odd on 0x07, 7N2 on 0x55, all at once
    l0 = tx_log.size();
    set_data(1, 9'h007); set_data(2, 9'h007); set_data(3, 9'h055);
    valid_v[3:1] = 3'b111;
    tick(1);
    valid_v = '0;
    tick(130);
    for (int i = 1; i < 4; i++) begin
      wq[i].delete();
      wq[i].push_back((i == 3) ? 9'h055 : 9'h007);
      check_frames(i, l0 + 2, wq[i]);
    end

    // Depth-4 FIFO with valid held over 0x01..0x06
    l0 = tx_log.size();
    wq[0].delete();
    for (int k = 1; k <= 6; k++) begin
      set_data(0, 9'(k));
      valid_v[0] = 1'b1;
      check($sformatf("fill_ready k%0d", k), 128'(ready_v[0]), 128'((k <= 5) ? 1 : 0));
      if (k <= 5) wq[0].push_back(9'(k));
      tick(1);
    end
    valid_v[0] = 1'b0;
    tick(520);
    check_frames(0, l0 + 2, wq[0]);

    // Random bursts on every configuration, all accepted from idle
    for (int r = 0; r < 3; r++) begin
      mx = 0;
      for (int i = 0; i < 4; i++) begin
        n[i] = (i == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 8));
        if (n[i] > mx) mx = n[i];
        wq[i].delete();
      end
      l0 = tx_log.size();
      for (int k = 0; k < mx; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (k < n[i]) begin
            w = 9'($urandom) & data_mask(i);
            set_data(i, w);
            valid_v[i] = 1'b1;
            wq[i].push_back(w);
            check($sformatf("rand_ready r%0d i%0d", r, i), 128'(ready_v[i]), 128'(1));
          end else begin
            valid_v[i] = 1'b0;
          end
        end
        tick(1);
      end
      valid_v = '0;
      tick(900);
      for (int i = 0; i < 4; i++) check_frames(i, l0 + 2, wq[i]);
    end

    // Reset mid-frame discards the frame and the queued word
    set_data(0, 9'h03C); valid_v[0] = 1'b1; tick(1);
    set_data(0, 9'h081); tick(1);
    valid_v[0] = 1'b0;
    tick(43);
    check("pre_reset_busy", {fc0, busy_v[0]}, {3'd1, 1'b1});
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", {tx_v[0], busy_v[0], ready_v[0], fc0}, {1'b1, 1'b0, 1'b1, 3'd0});
    tick(2);
    reset_n = 1'b1;
    l0 = tx_log.size();
    tick(300);
    check("post_reset_tx_idle", 128'(ones_in(0, 0, l0, 300)), 128'(300));
    check("post_reset_busy_low", 128'(ones_in(1, 0, l0, 300)), 128'(0));
    check("post_reset_no_done", 128'(ones_in(2, 0, l0, 300)), 128'(0));

    // New push after reset goes out normally
    l0 = tx_log.size();
    set_data(0, 9'h05A); valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    tick(110);
    wq[0].delete(); wq[0].push_back(9'h05A);
    check_frames(0, l0 + 2, wq[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usart_tx_buffered.md
# usart_tx_buffered

Parametrised USART transmitter with an internal transmit FIFO, valid/ready write handshake, selectable parity and 1 or 2 stop bits. It sits between a byte-producing core and the serial `tx` pin. The producer queues up to FIFO_DEPTH words without waiting on the line, and frames go out back-to-back with no idle gap while the FIFO is non-empty.

## Interface
- CLK_FREQ, 100000000, input clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (truncating), must be ≥ 2
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 8, FIFO entries, power of two, ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- data  input  DATA_BITS  word to queue
- valid  input  1  producer offers `data` this cycle
- ready  output  1  FIFO can accept; equals !full
- tx  output  1  serial line, idle high, registered
- busy  output  1  a frame is on the line (START through last STOP)
- done  output  1  one-cycle pulse at the end of each frame's last stop bit
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

## Operation
- Reset (async assert, sync release): tx=1, ready=1, busy=0, done=0, fifo_count=0, FSM=IDLE, baud and bit counters=0, FIFO pointers cleared.
- Asserting reset_n mid-frame aborts the frame immediately. tx returns high and queued data is discarded.
- Push: on an edge with valid && ready, data is written and fifo_count increments.
  - When full, ready=0 and valid is ignored, even if a pop occurs on the same edge.
- Pop: on an edge where the FSM is IDLE or finishing the last stop bit, and fifo_count>0, the head word loads into the shift register and the FSM enters START.
- Push and pop on the same edge leaves fifo_count unchanged.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0], LSB first, DATA_BITS bits.
  - PARITY: present only if PARITY≠0.
  - STOP: tx=1, STOP_BITS bits.
- Each state bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit advance.
- Parity bit:
  - even: XOR of all data bits.
  - odd: inverse of that XOR.
  - Computed from the popped word, so the total count of 1s across data and parity is even or odd respectively.
- End of last STOP bit: done pulses for one cycle.
  - FIFO non-empty: next START begins on the following cycle with no idle gap, and busy stays 1.
  - FIFO empty: FSM goes to IDLE and busy=0.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.

## Timing
- Push accepted at edge N into an empty FIFO with FSM IDLE:
  - fifo_count=1 after N.
  - Pop at N+1: tx=0, busy=1 and fifo_count=0 after N+1.
- tx changes only on baud boundaries and is registered, with no glitches.
- done is high for exactly the one cycle after the edge that ends the final stop bit.
- busy falls on the same edge that done rises, when the FIFO is empty.
- ready reflects the registered fifo_count. It goes low the cycle after fifo_count reaches FIFO_DEPTH.
- Throughput: one frame per (frame length × CLKS_PER_BIT) cycles, sustained.

## Test plan
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, giving CLKS_PER_BIT=10.
- 8N1, push 0xA5 once:
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each level holds 10 cycles, 100 cycles total.
  - done pulses once at cycle 100 after the start; busy=0 afterward.
- PARITY=2, push 0x07: parity bit 1. PARITY=1, push 0x07: parity bit 0. Both 11-bit frames.
- STOP_BITS=2, DATA_BITS=7, push 0x55: tx high for 20 cycles after bit 6, total frame 100 cycles.
- FIFO_DEPTH=4, valid held with 0x01..0x06 on consecutive cycles from idle:
  - Exactly 5 words accepted; ready=0 on the 6th cycle.
  - 0x01..0x05 transmitted back-to-back with no high gap between stop and start.
  - done pulses 5 times, 100 cycles apart.
- Reset mid-frame: push 0x3C and 0x81, then drop reset_n at cycle 45.
  - tx=1, busy=0, fifo_count=0, ready=1 immediately.
  - After release, no frame is sent until a new push.
